// File: rtl/color_phase_gen.sv
// Colour subcarrier phase generator: lock qualification, free-running carrier
// phase, PAL V-switch tracking and colour-burst window/phase per video line.
module color_phase_gen #(
    parameter int unsigned IS_PAL      = 1,
    parameter int unsigned PHASE_STEP  = 4,
    parameter int unsigned BURST_START = 99,
    parameter int unsigned BURST_LEN   = 40,
    parameter int unsigned LOCK_SETTLE = 1024
) (
    input  logic       clk_col16x,
    input  logic       rst_n,
    input  logic       clk_locked,
    input  logic       hs_start,
    input  logic       vs_start,
    output logic       ready,
    output logic [3:0] phase,
    output logic       pal_alt,
    output logic       burst,
    output logic [3:0] burst_phase
);

    localparam int unsigned PW = 4;
    localparam int unsigned DW = 10;
    localparam int unsigned BW = 8;
    localparam int unsigned LW = 16;

    localparam logic [PW-1:0] STEP      = PW'(PHASE_STEP % 16);
    localparam logic [DW-1:0] DLY_LOAD  = DW'(BURST_START - 1);
    localparam logic [BW-1:0] BST_LOAD  = BW'(BURST_LEN - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_SETTLE - 1);

    // Burst phase offsets: +225, +135 (PAL lines) and 180 degrees (NTSC)
    localparam logic [PW-1:0] OFS_PAL_EVEN = 4'd10;
    localparam logic [PW-1:0] OFS_PAL_ODD  = 4'd6;
    localparam logic [PW-1:0] OFS_NTSC     = 4'd8;

    localparam logic [1:0] S_WAIT_LOCK = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_DELAY     = 2'd2;
    localparam logic [1:0] S_BURST     = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          lock_s1, lock_s2;
    logic [LW-1:0] lock_cnt, lock_cnt_nxt;
    logic [DW-1:0] dly_cnt, dly_cnt_nxt;
    logic [BW-1:0] bst_cnt, bst_cnt_nxt;
    logic          ready_nxt;
    logic [PW-1:0] phase_nxt;
    logic          pal_alt_nxt;
    logic          burst_nxt;
    logic [PW-1:0] burst_phase_nxt;
    logic [PW-1:0] burst_ofs;

    // State register
    always_ff @(posedge clk_col16x) begin
        if (!rst_n) begin
            state <= S_WAIT_LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter and output computation
    always_comb begin
        state_nxt       = state;
        lock_cnt_nxt    = lock_cnt;
        dly_cnt_nxt     = dly_cnt;
        bst_cnt_nxt     = bst_cnt;
        ready_nxt       = ready;
        phase_nxt       = ready ? PW'(phase + STEP) : '0;
        pal_alt_nxt     = pal_alt;
        burst_nxt       = burst;
        burst_phase_nxt = '0;
        burst_ofs       = OFS_NTSC;

        if (state == S_WAIT_LOCK) begin
            ready_nxt   = 1'b0;
            phase_nxt   = '0;
            pal_alt_nxt = 1'b0;
            burst_nxt   = 1'b0;
            dly_cnt_nxt = '0;
            bst_cnt_nxt = '0;
            if (lock_s2) begin
                if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = S_IDLE;
                    ready_nxt    = 1'b1;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = LW'(lock_cnt + 1'b1);
                end
            end else begin
                lock_cnt_nxt = '0;
            end
        end else if (!lock_s2) begin
            // Lost lock overrides every line event
            state_nxt    = S_WAIT_LOCK;
            lock_cnt_nxt = '0;
            dly_cnt_nxt  = '0;
            bst_cnt_nxt  = '0;
            ready_nxt    = 1'b0;
            phase_nxt    = '0;
            pal_alt_nxt  = 1'b0;
            burst_nxt    = 1'b0;
        end else begin
            if (vs_start) begin
                pal_alt_nxt = 1'b0;
            end else if (hs_start && (IS_PAL != 0)) begin
                pal_alt_nxt = ~pal_alt;
            end

            case (state)
                S_IDLE: begin
                    if (hs_start) begin
                        state_nxt   = S_DELAY;
                        dly_cnt_nxt = DLY_LOAD;
                    end
                end
                S_DELAY: begin
                    if (hs_start) begin
                        dly_cnt_nxt = DLY_LOAD;
                    end else if (dly_cnt == '0) begin
                        state_nxt   = S_BURST;
                        burst_nxt   = 1'b1;
                        bst_cnt_nxt = BST_LOAD;
                    end else begin
                        dly_cnt_nxt = DW'(dly_cnt - 1'b1);
                    end
                end
                S_BURST: begin
                    if (hs_start) begin
                        state_nxt   = S_DELAY;
                        dly_cnt_nxt = DLY_LOAD;
                        burst_nxt   = 1'b0;
                    end else if (bst_cnt == '0) begin
                        state_nxt = S_IDLE;
                        burst_nxt = 1'b0;
                    end else begin
                        bst_cnt_nxt = BW'(bst_cnt - 1'b1);
                    end
                end
                default: begin
                    state_nxt = S_WAIT_LOCK;
                    burst_nxt = 1'b0;
                end
            endcase
        end

        if (IS_PAL != 0) begin
            burst_ofs = pal_alt_nxt ? OFS_PAL_ODD : OFS_PAL_EVEN;
        end
        if (burst_nxt) begin
            burst_phase_nxt = PW'(phase_nxt + burst_ofs);
        end
    end

    // Lock synchronizer, counters and registered outputs
    always_ff @(posedge clk_col16x) begin
        if (!rst_n) begin
            lock_s1     <= 1'b0;
            lock_s2     <= 1'b0;
            lock_cnt    <= '0;
            dly_cnt     <= '0;
            bst_cnt     <= '0;
            ready       <= 1'b0;
            phase       <= '0;
            pal_alt     <= 1'b0;
            burst       <= 1'b0;
            burst_phase <= '0;
        end else begin
            lock_s1     <= clk_locked;
            lock_s2     <= lock_s1;
            lock_cnt    <= lock_cnt_nxt;
            dly_cnt     <= dly_cnt_nxt;
            bst_cnt     <= bst_cnt_nxt;
            ready       <= ready_nxt;
            phase       <= phase_nxt;
            pal_alt     <= pal_alt_nxt;
            burst       <= burst_nxt;
            burst_phase <= burst_phase_nxt;
        end
    end

endmodule

// File: tb/tb_color_phase_gen.sv
// Directed bench: a PAL instance (step 4) and an NTSC instance (step 3)
// share all inputs; both use LOCK_SETTLE=16, BURST_START=5, BURST_LEN=3.
module tb_color_phase_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_locked = 1'b1;
    logic hs_start = 1'b0;
    logic vs_start = 1'b0;

    logic       ready_a, pal_a, burst_a;
    logic [3:0] phase_a, bp_a;
    logic       ready_b, pal_b, burst_b;
    logic [3:0] phase_b, bp_b;

    int n_checks = 0;
    int n_fails  = 0;

    logic       model_ready = 1'b0;
    logic [3:0] ph_a = 4'd0;
    logic [3:0] ph_b = 4'd0;
    logic       exp_pal = 1'b0;

    color_phase_gen #(
        .IS_PAL(1), .PHASE_STEP(4), .BURST_START(5), .BURST_LEN(3), .LOCK_SETTLE(16)
    ) dut_pal (
        .clk_col16x(clk), .rst_n(rst_n), .clk_locked(clk_locked),
        .hs_start(hs_start), .vs_start(vs_start),
        .ready(ready_a), .phase(phase_a), .pal_alt(pal_a),
        .burst(burst_a), .burst_phase(bp_a)
    );

    color_phase_gen #(
        .IS_PAL(0), .PHASE_STEP(3), .BURST_START(5), .BURST_LEN(3), .LOCK_SETTLE(16)
    ) dut_ntsc (
        .clk_col16x(clk), .rst_n(rst_n), .clk_locked(clk_locked),
        .hs_start(hs_start), .vs_start(vs_start),
        .ready(ready_b), .phase(phase_b), .pal_alt(pal_b),
        .burst(burst_b), .burst_phase(bp_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then advance the expected carrier phases
    task automatic tick();
        @(posedge clk);
        #1;
        if (model_ready) begin
            ph_a = ph_a + 4'd4;
            ph_b = ph_b + 4'd3;
        end
    endtask

    task automatic hs_pulse(input logic with_vs);
        hs_start = 1'b1;
        vs_start = with_vs;
        tick();
        hs_start = 1'b0;
        vs_start = 1'b0;
        if (with_vs) exp_pal = 1'b0;
        else         exp_pal = ~exp_pal;
    endtask

    task automatic check_burst(input string tag, input logic on);
        logic [3:0] e_a, e_b;
        e_a = on ? 4'(ph_a + (exp_pal ? 4'd6 : 4'd10)) : 4'd0;
        e_b = on ? 4'(ph_b + 4'd8) : 4'd0;
        chk({tag, "_burst_pal"}, 16'(burst_a), 16'(on));
        chk({tag, "_burst_ntsc"}, 16'(burst_b), 16'(on));
        chk({tag, "_bphase_pal"}, 16'(bp_a), 16'(e_a));
        chk({tag, "_bphase_ntsc"}, 16'(bp_b), 16'(e_b));
    endtask

    // Full line: hs at cycle t, burst expected at t+5..t+7
    task automatic run_line(input logic with_vs);
        hs_pulse(with_vs);
        chk("line_pal_alt", 16'(pal_a), 16'(exp_pal));
        chk("line_pal_alt_ntsc", 16'(pal_b), 16'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_burst("line", (k >= 5) && (k <= 7));
        end
    endtask

    initial begin
        logic [3:0] seq_a [4];
        logic [3:0] seq_b [4];
        seq_a = '{4'd4, 4'd8, 4'd12, 4'd0};
        seq_b = '{4'd3, 4'd6, 4'd9, 4'd12};

        // Reset state
        tick();
        tick();
        chk("rst_ready", 16'(ready_a), 16'd0);
        chk("rst_phase", 16'(phase_a), 16'd0);
        chk("rst_burst", 16'(burst_a), 16'd0);
        chk("rst_pal", 16'(pal_a), 16'd0);
        chk("rst_bphase", 16'(bp_a), 16'd0);
        rst_n = 1'b1;

        // Lock settle: ready on cycle 18
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 17) chk("settle_c17_ready", 16'(ready_a), 16'd0);
        end
        chk("settle_c18_ready_pal", 16'(ready_a), 16'd1);
        chk("settle_c18_ready_ntsc", 16'(ready_b), 16'd1);
        chk("settle_c18_phase", 16'(phase_a), 16'd0);
        model_ready = 1'b1;

        // Carrier phase sequence and wrap
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("phase_seq_pal", 16'(phase_a), 16'(seq_a[i]));
            chk("phase_seq_ntsc", 16'(phase_b), 16'(seq_b[i]));
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("phase_run_pal", 16'(phase_a), 16'(ph_a));
            chk("phase_run_ntsc", 16'(phase_b), 16'(ph_b));
        end

        // vs alone clears pal_alt (already 0), then 4 lines 1,0,1,0
        vs_start = 1'b1;
        tick();
        vs_start = 1'b0;
        chk("vs_pal", 16'(pal_a), 16'd0);
        for (int i = 0; i < 4; i++) run_line(1'b0);
        chk("four_lines_pal", 16'(pal_a), 16'd0);
        // vs coincident with hs suppresses the toggle
        run_line(1'b1);
        chk("vs_hs_pal", 16'(pal_a), 16'd0);
        for (int i = 0; i < 5; i++) run_line(1'b0);

        // Restart: second hs at t+6
        hs_pulse(1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_burst("restart_first", k == 5);
        end
        hs_pulse(1'b0);
        check_burst("restart_t6", 1'b0);
        for (int k = 7; k <= 14; k++) begin
            tick();
            check_burst("restart_second", (k >= 11) && (k <= 13));
        end

        // Lock dropped during burst
        hs_pulse(1'b0);
        for (int k = 1; k <= 5; k++) tick();
        chk("drop_burst_before", 16'(burst_a), 16'd1);
        clk_locked = 1'b0;
        tick();
        tick();
        chk("drop_ready_c2", 16'(ready_a), 16'd1);
        tick();
        model_ready = 1'b0;
        ph_a = 4'd0;
        ph_b = 4'd0;
        exp_pal = 1'b0;
        chk("drop_ready", 16'(ready_a), 16'd0);
        chk("drop_burst", 16'(burst_a), 16'd0);
        chk("drop_phase", 16'(phase_a), 16'd0);
        chk("drop_pal", 16'(pal_a), 16'd0);
        chk("drop_bphase", 16'(bp_a), 16'd0);
        chk("drop_ready_ntsc", 16'(ready_b), 16'd0);

        // hs ignored while waiting for lock
        clk_locked = 1'b1;
        hs_pulse(1'b0);
        exp_pal = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        chk("nolock_hs_burst", 16'(burst_a), 16'd0);
        chk("nolock_hs_pal", 16'(pal_a), 16'd0);
        for (int k = 0; k < 20; k++) tick();
        chk("relock_ready", 16'(ready_a), 16'd1);

        // Reset with lock held high, one-cycle glitch at cycle 10
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst2_ready", 16'(ready_a), 16'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            if (c == 10) clk_locked = 1'b0;
            if (c == 20) hs_start = 1'b1;
            tick();
            clk_locked = 1'b1;
            hs_start = 1'b0;
            if (c == 18) chk("glitch_c18_ready", 16'(ready_a), 16'd0);
            if (c == 26) chk("glitch_hs_burst", 16'(burst_a), 16'd0);
            if (c == 27) chk("glitch_c27_ready", 16'(ready_a), 16'd0);
        end
        chk("glitch_c28_ready", 16'(ready_a), 16'd1);
        chk("glitch_c28_pal", 16'(pal_a), 16'd0);
        model_ready = 1'b1;

        // Reset asserted mid-burst
        hs_pulse(1'b0);
        for (int k = 1; k <= 5; k++) tick();
        check_burst("preRst", 1'b1);
        rst_n = 1'b0;
        tick();
        chk("midrst_burst", 16'(burst_a), 16'd0);
        chk("midrst_ready", 16'(ready_a), 16'd0);
        chk("midrst_phase", 16'(phase_a), 16'd0);
        chk("midrst_bphase", 16'(bp_a), 16'd0);
        chk("midrst_pal", 16'(pal_a), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
